// File: rtl/nx_fifo_rd_stream_adapter.sv
// nx_fifo_rd_stream_adapter
// Read-side stage for the nx_fifo_ram_1r1w family. Issues fifo_ren against a
// credit of DEPTH = RD_LAT+1 buffer slots, absorbs the RAM read latency in a
// small circular skid buffer and presents a bubble-free valid/ready stream.
// Each word travels with its read-error flag.

// One skid-buffer entry {err,data}. Only reset zeroes it; a clear simply
// rewinds the pointers, so stale contents are never observable.
module nx_fifo_rd_skid_slot #(
  parameter int W = 84
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] q
);

  // Capture the returning word when this slot is the write target.
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= wdata;
  end

endmodule

module nx_fifo_rd_stream_adapter #(
  parameter  int DATA_W = 83,
  parameter  int RD_LAT = 1,
  // Buffer must cover every read that can be in flight plus the head word.
  localparam int DEPTH  = RD_LAT + 1,
  // Two bits for RD_LAT 1..2; widens to three at RD_LAT=3 so DEPTH=4 fits.
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              fifo_clear,
  input  logic              fifo_empty,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_rerr,
  input  logic              fifo_underflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  held_cnt,
  output logic              underflow_seen
);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  logic              flush;
  logic              pop;
  logic              ret;
  logic [RD_LAT-1:0] vld_pipe;
  logic [CNT_W:0]    infl_cnt;
  logic [CNT_W:0]    credit_use;
  logic [CNT_W:0]    credit_lim;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DEPTH-1:0]  slot_we;
  entry_t            ret_entry;
  entry_t            slot_q [DEPTH];
  entry_t            head;

  // Non-power-of-two depths (RD_LAT=2) need an explicit wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  // Reset and clear discard buffered and in-flight words identically.
  assign flush      = ~rst_n | clear;
  assign fifo_clear = clear;

  assign pop = out_valid & out_ready;
  assign ret = vld_pipe[RD_LAT-1];

  // Count outstanding reads still travelling through the RAM pipeline.
  always_comb begin
    infl_cnt = '0;
    for (int k = 0; k < RD_LAT; k++)
      infl_cnt = infl_cnt + {{CNT_W{1'b0}}, vld_pipe[k]};
  end

  // A slot freed by this cycle's pop can be re-credited immediately; that is
  // what keeps the stream at one word per cycle without bubbles.
  assign credit_use = {1'b0, held_cnt} + infl_cnt;
  assign credit_lim = DEPTH_C + {{CNT_W{1'b0}}, pop};
  assign fifo_ren   = rst_n & ~clear & ~fifo_empty & (credit_use < credit_lim);

  // Age each issued read by one stage per cycle until its data returns.
  always_ff @(posedge clk) begin
    if (flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= fifo_ren;
      for (int k = 1; k < RD_LAT; k++)
        vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  assign ret_entry = {fifo_rerr, fifo_rdata};

  // Circular buffer of skid slots; a returning word lands at wr_ptr unless
  // it arrives in a flush cycle, in which case it is dropped.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_we[i] = ret & ~flush & (wr_ptr == PTR_W'(i));

    nx_fifo_rd_skid_slot #(
      .W (DATA_W + 1)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (slot_we[i]),
      .wdata (ret_entry),
      .q     (slot_q[i])
    );
  end

  // Pointer and occupancy bookkeeping; return and pop in one cycle cancel.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      held_cnt <= '0;
    end else begin
      if (ret) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({ret, pop})
        2'b10:   held_cnt <= held_cnt + 1'b1;
        2'b01:   held_cnt <= held_cnt - 1'b1;
        default: held_cnt <= held_cnt;
      endcase
    end
  end

  // Head entry drives the stream; it only moves on a completed handshake.
  assign head      = slot_q[rd_ptr];
  assign out_valid = (held_cnt != '0);
  assign out_data  = head.data;
  assign out_err   = head.err;

  // Sticky underflow flag; survives clear, only reset drops it.
  always_ff @(posedge clk) begin
    if (!rst_n)              underflow_seen <= 1'b0;
    else if (fifo_underflow) underflow_seen <= 1'b1;
  end

endmodule

// File: tb/tb_nx_fifo_rd_stream_adapter.sv
// Bench for nx_fifo_rd_stream_adapter: three DUTs (RD_LAT 1,2,3) share the
// stimulus; each has its own behavioural RAM-FIFO and a queue-based model
// that is compared against the DUT every cycle, plus literal expectations.
module tb_nx_fifo_rd_stream_adapter;

  localparam int DW   = 83;
  localparam int NL   = 3;
  localparam int MEMN = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clear, out_ready, force_empty, fifo_underflow, chk_en;
  logic [DW:0] mem [MEMN];
  int wr_i = 0;
  int checks = 0;
  int failures = 0;

  logic [NL-1:0]         ren_v, vld_v, err_v, uf_v, fclr_v, idle_v;
  logic [NL-1:0][DW-1:0] dat_v;
  logic [NL-1:0][2:0]    cnt_v;

  logic [19:0]   ren_h [NL];
  logic [19:0]   vld_h [NL];
  logic [7:0]    err_h [NL];
  int            ndel  [NL];
  int            nren  [NL];
  logic          got   [NL];
  logic [DW-1:0] d3    [NL];
  logic [DW-1:0] first_w [NL];
  logic [19:0]   exp_v1 [NL];
  int            exp_first [NL];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_val(input int n);
    logic [15:0] t;
    t = n[15:0];
    return {t, ~t, 51'(n) * 51'd1000003 + 51'd77};
  endfunction

  function automatic logic [DW:0] junk();
    return (DW+1)'({$urandom, $urandom, $urandom});
  endfunction

  task automatic push(input logic e);
    mem[wr_i % MEMN] = {e, word_val(wr_i)};
    wr_i++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    out_ready = 1'b1;
    force_empty = 1'b0;
    while (!(&idle_v) && n < 100) begin
      step();
      n++;
    end
    chk(nm, 128'(&idle_v), 128'(1));
  endtask

  for (genvar L = 0; L < NL; L++) begin : g_lane
    localparam int LAT = L + 1;
    localparam int DEP = LAT + 1;
    localparam int CW  = $clog2(DEP + 1);

    logic          ren, vld, oerr, fclr, ufs, rerr, empty;
    logic [DW-1:0] odat, rdata;
    logic [CW-1:0] hcnt;
    logic [DW:0]   pipe_d [LAT];
    int            rd_i = 0;

    // Behavioural RAM FIFO: pops on ren, returns the word LAT cycles later;
    // the read port carries random junk whenever no word is due.
    assign empty = force_empty || (rd_i == wr_i);
    always @(posedge clk) begin
      pipe_d[0] <= ren ? mem[rd_i % MEMN] : junk();
      for (int k = 1; k < LAT; k++) pipe_d[k] <= pipe_d[k-1];
      if (ren) rd_i <= rd_i + 1;
    end
    assign {rerr, rdata} = pipe_d[LAT-1];

    nx_fifo_rd_stream_adapter #(
      .DATA_W (DW),
      .RD_LAT (LAT)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (clear),
      .fifo_clear     (fclr),
      .fifo_empty     (empty),
      .fifo_ren       (ren),
      .fifo_rdata     (rdata),
      .fifo_rerr      (rerr),
      .fifo_underflow (fifo_underflow),
      .out_valid      (vld),
      .out_ready      (out_ready),
      .out_data       (odat),
      .out_err        (oerr),
      .held_cnt       (hcnt),
      .underflow_seen (ufs)
    );

    assign ren_v[L]  = ren;
    assign vld_v[L]  = vld;
    assign err_v[L]  = oerr;
    assign uf_v[L]   = ufs;
    assign fclr_v[L] = fclr;
    assign dat_v[L]  = odat;
    assign cnt_v[L]  = 3'(hcnt);

    // Model: a queue of held words and a list of in-flight reads.
    logic [DW:0]    m_held [$];
    logic [DW:0]    m_fl_d [LAT];
    logic [LAT-1:0] m_fl_v = '0;
    int             m_rd   = 0;
    int             m_cnt  = 0;
    logic           m_uf   = 1'b0;

    assign idle_v[L] = (rd_i == wr_i) && (m_cnt == 0) && (m_fl_v == '0);

    always @(negedge clk) begin
      int          infl;
      logic        pop, eren, ret;
      logic [DW:0] head;
      infl = 0;
      for (int k = 0; k < LAT; k++) infl += int'(m_fl_v[k]);
      pop  = (m_held.size() != 0) && out_ready;
      eren = rst_n && !clear && !empty && ((m_held.size() + infl - int'(pop)) < DEP);
      head = (m_held.size() != 0) ? m_held[0] : '0;
      if (chk_en) begin
        chk($sformatf("L%0d_ren", LAT), 128'(ren), 128'(eren));
        chk($sformatf("L%0d_valid", LAT), 128'(vld), 128'(m_held.size() != 0));
        chk($sformatf("L%0d_held_cnt", LAT), 128'(hcnt), 128'(m_held.size()));
        chk($sformatf("L%0d_fifo_clear", LAT), 128'(fclr), 128'(clear));
        chk($sformatf("L%0d_underflow_seen", LAT), 128'(ufs), 128'(m_uf));
        chk($sformatf("L%0d_credit", LAT), 128'((int'(hcnt) + infl) <= DEP), 128'(1));
        if (m_held.size() != 0) begin
          chk($sformatf("L%0d_data", LAT), 128'(odat), 128'(head[DW-1:0]));
          chk($sformatf("L%0d_err", LAT), 128'(oerr), 128'(head[DW]));
        end
      end
      if (!rst_n || clear) begin
        m_held.delete();
        m_fl_v = '0;
      end else begin
        ret = m_fl_v[LAT-1];
        if (pop) void'(m_held.pop_front());
        if (ret) m_held.push_back(m_fl_d[LAT-1]);
        for (int k = LAT - 1; k > 0; k--) begin
          m_fl_v[k] = m_fl_v[k-1];
          m_fl_d[k] = m_fl_d[k-1];
        end
        m_fl_v[0] = eren;
        m_fl_d[0] = eren ? mem[m_rd % MEMN] : '0;
        if (eren) m_rd++;
      end
      m_cnt = m_held.size();
      if (!rst_n)              m_uf = 1'b0;
      else if (fifo_underflow) m_uf = 1'b1;
    end
  end

  initial begin
    int b;
    exp_v1 = '{20'h0007C, 20'h000F8, 20'h001F0};
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0; force_empty = 1'b0;
    fifo_underflow = 1'b0; chk_en = 1'b0;

    // Reset with five words waiting in the FIFO.
    for (int i = 0; i < 5; i++) push(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", 128'(vld_v), 128'(0));
    chk("rst_ren", 128'(ren_v), 128'(0));
    chk("rst_uf", 128'(uf_v), 128'(0));
    for (int l = 0; l < NL; l++) chk($sformatf("rst_cnt%0d", l), 128'(cnt_v[l]), 128'(0));

    // 1: release reset, ready high: ren cycles 0..4, valid from RD_LAT+1.
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int l = 0; l < NL; l++) begin ren_h[l] = '0; vld_h[l] = '0; end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        ren_h[l][c] = ren_v[l];
        vld_h[l][c] = vld_v[l];
      end
      step();
    end
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("t1_ren_L%0d", l + 1), 128'(ren_h[l]), 128'(20'h0001F));
      chk($sformatf("t1_valid_L%0d", l + 1), 128'(vld_h[l]), 128'(exp_v1[l]));
    end

    // 2: ready low with ten words: exactly DEPTH reads, then full stop.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(1'b0);
    for (int l = 0; l < NL; l++) nren[l] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) nren[l] += int'(ren_v[l]);
      step();
    end
    @(negedge clk);
    chk("t2_ren_stopped", 128'(ren_v), 128'(0));
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("t2_nren_L%0d", l + 1), 128'(nren[l]), 128'(l + 2));
      chk($sformatf("t2_held_L%0d", l + 1), 128'(cnt_v[l]), 128'(l + 2));
    end
    step();
    out_ready = 1'b1;
    for (int l = 0; l < NL; l++) vld_h[l] = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) chk("t2_ren_resume", 128'(ren_v), 128'(3'b111));
      for (int l = 0; l < NL; l++) vld_h[l][c] = vld_v[l];
      step();
    end
    for (int l = 0; l < NL; l++)
      chk($sformatf("t2_nogap_L%0d", l + 1), 128'(vld_h[l]), 128'(20'h003FF));

    // 3: third word carries an error flag; it is delivered, data intact.
    b = wr_i;
    for (int i = 0; i < 5; i++) push(i == 2);
    for (int l = 0; l < NL; l++) begin err_h[l] = '0; ndel[l] = 0; d3[l] = '0; end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        if (vld_v[l] && out_ready && ndel[l] < 8) begin
          err_h[l][ndel[l]] = err_v[l];
          if (ndel[l] == 2) d3[l] = dat_v[l];
          ndel[l]++;
        end
      end
      step();
    end
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("t3_count_L%0d", l + 1), 128'(ndel[l]), 128'(5));
      chk($sformatf("t3_err_L%0d", l + 1), 128'(err_h[l]), 128'(8'h04));
      chk($sformatf("t3_data_L%0d", l + 1), 128'(d3[l]), 128'(word_val(b + 2)));
    end

    // 4: clear while RD_LAT=2 lane holds 2 words with 1 returning.
    out_ready = 1'b0;
    b = wr_i;
    for (int i = 0; i < 3; i++) push(1'b0);
    repeat (4) step();
    clear = 1'b1;
    @(negedge clk);
    chk("t4_held_before", 128'(cnt_v[1]), 128'(2));
    chk("t4_fifo_clear", 128'(fclr_v), 128'(3'b111));
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("t4_valid_after", 128'(vld_v), 128'(0));
    for (int l = 0; l < NL; l++) chk($sformatf("t4_cnt_L%0d", l + 1), 128'(cnt_v[l]), 128'(0));
    step();
    push(1'b0);
    out_ready = 1'b1;
    exp_first = '{b + 2, b + 3, b + 3};
    for (int l = 0; l < NL; l++) begin got[l] = 1'b0; first_w[l] = '0; end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      for (int l = 0; l < NL; l++)
        if (!got[l] && vld_v[l]) begin got[l] = 1'b1; first_w[l] = dat_v[l]; end
      step();
    end
    for (int l = 0; l < NL; l++)
      chk($sformatf("t4_first_L%0d", l + 1), 128'(first_w[l]), 128'(word_val(exp_first[l])));
    drain("t4_drain");

    // 5: sticky underflow flag survives clear, drops only on reset.
    fifo_underflow = 1'b1;
    @(negedge clk);
    chk("t5_uf_before", 128'(uf_v), 128'(0));
    step();
    fifo_underflow = 1'b0;
    @(negedge clk);
    chk("t5_uf_set", 128'(uf_v), 128'(3'b111));
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("t5_uf_after_clear", 128'(uf_v), 128'(3'b111));
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_uf_after_reset", 128'(uf_v), 128'(0));
    step();

    // 6: random ready/empty/clear/reset traffic, checked by the models.
    for (int c = 0; c < 800; c++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      force_empty    = ($urandom_range(0, 5) == 0);
      clear          = ($urandom_range(0, 99) == 0);
      fifo_underflow = ($urandom_range(0, 49) == 0);
      rst_n          = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 1) == 1) push($urandom_range(0, 7) == 0);
      step();
    end
    clear = 1'b0; rst_n = 1'b1; fifo_underflow = 1'b0;
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
